// File: rtl/dla_quant_pkg.sv
// Shared types and helpers for the DLA output-path dequantizer.
package dla_quant_pkg;

    localparam int HWORD = 16;

    // Saturation bounds for a signed 16-bit result, held at the width of the
    // rounded/shifted intermediate so comparisons need no extension.
    localparam logic signed [39:0] SAT_MAX = 40'sd32767;
    localparam logic signed [39:0] SAT_MIN = -40'sd32768;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_e;

    // Per-burst configuration, latched when a burst starts.
    typedef struct packed {
        logic signed [HWORD-1:0] bias;
        logic signed [HWORD-1:0] scale;
        logic [4:0]              shift;
        logic                    bypass;
    } cfg_t;

    // Clamp a wide signed value into the signed 16-bit range.
    function automatic logic signed [15:0] sat16(input logic signed [39:0] x);
        logic signed [15:0] r;
        if (x > SAT_MAX) begin
            r = SAT_MAX[15:0];
        end else if (x < SAT_MIN) begin
            r = SAT_MIN[15:0];
        end else begin
            r = x[15:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/dequan_stream_if.sv
// Config, upstream and downstream handshake bundle for dequan_stream.
// master = the side that configures and feeds the block; slave = the block.
interface dequan_stream_if #(
    parameter int DW    = 16,
    parameter int LEN_W = 16
);
    logic                    cfg_we;
    logic signed [DW-1:0]    cfg_bias;
    logic signed [DW-1:0]    cfg_scale;
    logic [4:0]              cfg_shift;
    logic [LEN_W-1:0]        cfg_len;
    logic                    cfg_bypass;

    logic                    in_valid;
    logic                    in_ready;
    logic signed [DW-1:0]    in_data;

    logic                    out_valid;
    logic                    out_ready;
    logic signed [DW-1:0]    out_data;
    logic                    out_last;

    logic                    busy;
    logic                    done;

    modport master (
        output cfg_we, cfg_bias, cfg_scale, cfg_shift, cfg_len, cfg_bypass,
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last, busy, done
    );

    modport slave (
        input  cfg_we, cfg_bias, cfg_scale, cfg_shift, cfg_len, cfg_bypass,
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last, busy, done
    );

endinterface

// File: rtl/dequan_stream_datapath.sv
// Three-stage dequantize pipe: bias add, scale multiply, round/shift/saturate.
// Each stage carries a valid bit and the burst-last tag; ready chains backwards.
module dequan_datapath
    import dla_quant_pkg::*;
#(
    parameter int DW = HWORD
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 bypass_i,
    input  logic signed [DW-1:0] bias_i,
    input  logic signed [DW-1:0] scale_i,
    input  logic [4:0]           shift_i,
    input  logic                 in_valid_i,
    input  logic                 in_last_i,
    input  logic signed [DW-1:0] in_data_i,
    output logic                 in_ready_o,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic signed [DW-1:0] out_data_o,
    output logic                 out_last_o
);

    localparam int SW = DW + 1;     // bias sum cannot overflow one extra bit
    localparam int PW = 2 * DW + 1; // product of SW-bit sum and DW-bit scale

    logic                 s1_valid_q, s1_valid_d;
    logic                 s1_last_q,  s1_last_d;
    logic signed [SW-1:0] s1_sum_q,   s1_sum_d;

    logic                 s2_valid_q, s2_valid_d;
    logic                 s2_last_q,  s2_last_d;
    logic signed [PW-1:0] s2_prod_q,  s2_prod_d;

    logic                 s3_valid_q, s3_valid_d;
    logic                 s3_last_q,  s3_last_d;
    logic signed [DW-1:0] s3_data_q,  s3_data_d;

    logic                 adv1, adv2, adv3;
    logic signed [39:0]   prod_ext, rnd, shifted;
    logic signed [DW-1:0] result;

    // Stage-3 arithmetic: round half toward +inf, arithmetic shift, saturate.
    always_comb begin
        prod_ext = 40'(s2_prod_q);
        rnd      = (shift_i != 5'd0) ? (40'sd1 <<< (shift_i - 5'd1)) : 40'sd0;
        shifted  = (prod_ext + rnd) >>> shift_i;
        result   = bypass_i ? s2_prod_q[DW-1:0] : sat16(shifted);
    end

    // Ready chaining and next-state for all three stages.
    always_comb begin
        // NOTE: every _d gets its hold value first; a missing default would infer a latch.
        s1_valid_d = s1_valid_q;
        s1_last_d  = s1_last_q;
        s1_sum_d   = s1_sum_q;
        s2_valid_d = s2_valid_q;
        s2_last_d  = s2_last_q;
        s2_prod_d  = s2_prod_q;
        s3_valid_d = s3_valid_q;
        s3_last_d  = s3_last_q;
        s3_data_d  = s3_data_q;

        adv3 = !s3_valid_q || out_ready_i;
        adv2 = !s2_valid_q || adv3;
        adv1 = !s1_valid_q || adv2;

        if (adv1) begin
            s1_valid_d = in_valid_i;
            if (in_valid_i) begin
                s1_last_d = in_last_i;
                s1_sum_d  = bypass_i ? SW'(in_data_i) : SW'(in_data_i) + SW'(bias_i);
            end
        end

        if (adv2) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_last_d = s1_last_q;
                s2_prod_d = bypass_i ? PW'(s1_sum_q) : PW'(s1_sum_q) * PW'(scale_i);
            end
        end

        // Output data and tag only change when a new element is loaded, so
        // they stay stable while the downstream stalls.
        if (adv3) begin
            s3_valid_d = s2_valid_q;
            if (s2_valid_q) begin
                s3_last_d = s2_last_q;
                s3_data_d = result;
            end
        end
    end

    // Pipeline registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments only, so every stage samples pre-edge values.
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_sum_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_last_q  <= 1'b0;
            s2_prod_q  <= '0;
            s3_valid_q <= 1'b0;
            s3_last_q  <= 1'b0;
            s3_data_q  <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_last_q  <= s1_last_d;
            s1_sum_q   <= s1_sum_d;
            s2_valid_q <= s2_valid_d;
            s2_last_q  <= s2_last_d;
            s2_prod_q  <= s2_prod_d;
            s3_valid_q <= s3_valid_d;
            s3_last_q  <= s3_last_d;
            s3_data_q  <= s3_data_d;
        end
    end

    assign in_ready_o  = adv1;
    assign out_valid_o = s3_valid_q;
    assign out_data_o  = s3_data_q;
    assign out_last_o  = s3_last_q;

endmodule

// File: rtl/dequan_stream.sv
// Streaming dequantizer top: config latch, burst FSM, length counter and
// done pulse around the three-stage arithmetic pipe.
module dequan_stream
    import dla_quant_pkg::*;
#(
    parameter int DW    = HWORD,
    parameter int LEN_W = 16
) (
    input  logic         clk,
    input  logic         rst,
    dequan_stream_if.slave bus
);

    state_e           state_q, state_d;
    cfg_t             cfg_q,   cfg_d;
    logic [LEN_W-1:0] len_q,   len_d;
    logic [LEN_W-1:0] cnt_q,   cnt_d;
    logic             done_q,  done_d;

    logic             dp_in_valid;
    logic             dp_in_ready;
    logic             in_fire;
    logic             out_fire;
    logic             last_tag;

    assign in_fire  = bus.in_valid & bus.in_ready;
    assign out_fire = bus.out_valid & bus.out_ready;
    // The element accepted while the counter sits at len-1 closes the burst.
    assign last_tag = (cnt_q == len_q - LEN_W'(1));

    // Burst FSM next-state, config latch and counter update.
    always_comb begin
        state_d     = state_q;
        cfg_d       = cfg_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        done_d      = 1'b0;
        dp_in_valid = 1'b0;

        unique case (state_q)
            IDLE: begin
                // A zero-length request is a no-op: no burst, no done pulse.
                if (bus.cfg_we && (bus.cfg_len != '0)) begin
                    cfg_d.bias   = bus.cfg_bias;
                    cfg_d.scale  = bus.cfg_scale;
                    cfg_d.shift  = bus.cfg_shift;
                    cfg_d.bypass = bus.cfg_bypass;
                    len_d        = bus.cfg_len;
                    cnt_d        = '0;
                    state_d      = RUN;
                end
            end
            RUN: begin
                dp_in_valid = bus.in_valid;
                if (in_fire) begin
                    cnt_d = cnt_q + LEN_W'(1);
                    if (last_tag) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (out_fire && bus.out_last) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control registers with synchronous reset; a mid-burst reset drops the burst.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cfg_q   <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cfg_q   <= cfg_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    dequan_datapath #(
        .DW(DW)
    ) u_datapath (
        .clk         (clk),
        .rst         (rst),
        .bypass_i    (cfg_q.bypass),
        .bias_i      (cfg_q.bias),
        .scale_i     (cfg_q.scale),
        .shift_i     (cfg_q.shift),
        .in_valid_i  (dp_in_valid),
        .in_last_i   (last_tag),
        .in_data_i   (bus.in_data),
        .in_ready_o  (dp_in_ready),
        .out_valid_o (bus.out_valid),
        .out_ready_i (bus.out_ready),
        .out_data_o  (bus.out_data),
        .out_last_o  (bus.out_last)
    );

    assign bus.in_ready = (state_q == RUN) & dp_in_ready;
    assign bus.busy     = (state_q != IDLE);
    assign bus.done     = done_q;

endmodule

// File: tb/tb_dequan_stream.sv
// Self-checking bench for dequan_stream: directed scenarios plus randomized
// bursts compared against an arithmetic reference model.
`timescale 1ns/1ps
module tb_dequan_stream;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dequan_stream_if #(.DW(16), .LEN_W(16)) bus();

    dequan_stream #(.DW(16), .LEN_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int d;
        bit l;
    } obs_t;

    obs_t obs_q[$];
    int   stim[$];
    int   checks   = 0;
    int   errors   = 0;
    int   done_cnt = 0;

    bit                 prev_stall = 1'b0;
    logic signed [15:0] prev_d;
    logic               prev_l;

    // Output monitor: records handshakes, counts done pulses, checks hold under stall.
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                checks++;
                if (bus.out_valid !== 1'b1 || bus.out_data !== prev_d || bus.out_last !== prev_l) begin
                    errors++;
                    $display("FAIL stall_hold: got valid=%0b data=%0d last=%0b, expected valid=1 data=%0d last=%0b",
                             bus.out_valid, bus.out_data, bus.out_last, prev_d, prev_l);
                end
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_d     = bus.out_data;
            prev_l     = bus.out_last;
            if (bus.out_valid && bus.out_ready) obs_q.push_back('{d: int'(bus.out_data), l: bus.out_last});
            if (bus.done) done_cnt++;
        end
    end

    // Reference: (x + bias) * scale, add half an LSB, floor-shift, clamp.
    function automatic int model(input int din, input int bias, input int scale,
                                 input int shift, input bit byp);
        longint s, p;
        if (byp) return din;
        s = longint'(din) + longint'(bias);
        p = s * longint'(scale);
        if (shift > 0) p = p + (longint'(1) <<< (shift - 1));
        p = p >>> shift;
        if (p > 32767) p = 32767;
        if (p < -32768) p = -32768;
        return int'(p);
    endfunction

    task automatic run_burst(input string name, input int bias, input int scale, input int shift,
                             input bit byp, input int len, input int st_lo, input int st_hi,
                             input bit rnd, input int poke_c, input bit chk_lat);
        int idx = 0, c0 = -1, c1 = -1, c_last = -1, c_done = -1, d0, tmp, exp, n;
        bit fin = 1'b0;
        obs_q.delete();
        d0 = done_cnt;
        bus.cfg_bias   = 16'(bias);
        bus.cfg_scale  = 16'(scale);
        bus.cfg_shift  = 5'(shift);
        bus.cfg_len    = 16'(len);
        bus.cfg_bypass = byp;
        bus.cfg_we     = 1'b1;
        bus.in_valid   = 1'b0;
        bus.out_ready  = 1'b1;
        @(posedge clk); #1;
        bus.cfg_we = 1'b0;
        for (int c = 0; c < 600 && !fin; c++) begin
            bus.in_valid  = (idx < len) && (!rnd || $urandom_range(3) != 0);
            tmp           = (idx < len) ? stim[idx] : 0;
            bus.in_data   = bus.in_valid ? tmp[15:0] : 16'($urandom);
            bus.out_ready = !(c >= st_lo && c <= st_hi) && (!rnd || $urandom_range(2) != 0);
            if (c == poke_c) begin
                bus.cfg_we     = 1'b1;
                bus.cfg_len    = 16'(len + 4);
                bus.cfg_bypass = !byp;
                bus.cfg_bias   = 16'(bias + 1);
            end else begin
                bus.cfg_we = 1'b0;
            end
            @(negedge clk); #1;
            if (bus.out_valid && c1 < 0) c1 = c;
            if (bus.out_valid && bus.out_ready && bus.out_last) c_last = c;
            if (bus.in_valid && bus.in_ready) begin
                if (idx == 0) c0 = c;
                idx++;
            end else if (bus.in_valid) begin
                checks++;
                if (idx - obs_q.size() != 3 || bus.out_ready) begin
                    errors++;
                    $display("FAIL %s in_ready_drop: in-flight=%0d out_ready=%0b, expected 3 and 0",
                             name, idx - obs_q.size(), bus.out_ready);
                end
            end
            if (done_cnt != d0) begin
                c_done = c;
                fin    = 1'b1;
            end
            @(posedge clk); #1;
        end
        bus.in_valid  = 1'b0;
        bus.cfg_we    = 1'b0;
        bus.out_ready = 1'b1;

        checks++;
        if (!fin) begin
            errors++;
            $display("FAIL %s timeout: done not seen, accepted=%0d outputs=%0d expected len=%0d", name, idx, obs_q.size(), len);
        end else if (c_done != c_last + 1) begin
            errors++;
            $display("FAIL %s done_timing: done cycle %0d, expected %0d", name, c_done, c_last + 1);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (done_cnt != d0 + 1 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL %s done_once: done pulses=%0d busy=%0b, expected 1 and 0", name, done_cnt - d0, bus.busy);
        end
        checks++;
        if (obs_q.size() != len) begin
            errors++;
            $display("FAIL %s out_count: got %0d, expected %0d", name, obs_q.size(), len);
        end
        n = (obs_q.size() < len) ? obs_q.size() : len;
        for (int i = 0; i < n; i++) begin
            exp = model(stim[i], bias, scale, shift, byp);
            checks++;
            if (obs_q[i].d != exp || obs_q[i].l != (i == len - 1)) begin
                errors++;
                $display("FAIL %s elem%0d: got data=%0d last=%0b, expected data=%0d last=%0b",
                         name, i, obs_q[i].d, obs_q[i].l, exp, (i == len - 1));
            end
        end
        if (chk_lat) begin
            checks++;
            if (c1 - c0 != 3) begin
                errors++;
                $display("FAIL %s latency: got %0d cycles, expected 3", name, c1 - c0);
            end
        end
    endtask

    task automatic check_idle_outputs(input string name);
        checks++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.out_last !== 1'b0 ||
            bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.out_data !== 16'sd0) begin
            errors++;
            $display("FAIL %s: in_ready=%0b out_valid=%0b out_last=%0b busy=%0b done=%0b out_data=%0d, expected all 0",
                     name, bus.in_ready, bus.out_valid, bus.out_last, bus.busy, bus.done, bus.out_data);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.cfg_we = 1'b0; bus.cfg_bias = '0; bus.cfg_scale = '0; bus.cfg_shift = '0;
        bus.cfg_len = '0; bus.cfg_bypass = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("reset_values");
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_idle_outputs("after_reset_release");
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        stim = '{100};
        run_burst("basic", 10, 1, 0, 1'b0, 1, -1, -1, 1'b0, -1, 1'b1);
    endtask

    task automatic test_rounding();
        stim = '{5, -5};
        run_burst("rounding", 0, 3, 2, 1'b0, 2, -1, -1, 1'b0, -1, 1'b0);
    endtask

    task automatic test_saturation();
        stim = '{32767};
        run_burst("sat_pos", 100, 1, 0, 1'b0, 1, -1, -1, 1'b0, -1, 1'b0);
        stim = '{-32768};
        run_burst("sat_neg", -100, 1, 0, 1'b0, 1, -1, -1, 1'b0, -1, 1'b0);
    endtask

    task automatic test_backpressure();
        stim.delete();
        for (int i = 0; i < 8; i++) stim.push_back(int'($urandom_range(2000)) - 1000);
        run_burst("backpressure", 3, -2, 1, 1'b0, 8, 4, 9, 1'b0, -1, 1'b0);
    endtask

    task automatic test_bypass_cfg();
        int d0;
        stim = '{7, -1, 300};
        run_burst("bypass", 55, -3, 4, 1'b1, 3, -1, -1, 1'b0, 1, 1'b1);
        d0 = done_cnt;
        bus.cfg_we  = 1'b1;
        bus.cfg_len = '0;
        @(posedge clk); #1;
        bus.cfg_we = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (bus.busy !== 1'b0 || bus.in_ready !== 1'b0) begin
                errors++;
                $display("FAIL len0_idle: busy=%0b in_ready=%0b, expected 0 0", bus.busy, bus.in_ready);
            end
        end
        @(posedge clk); #1;
        checks++;
        if (done_cnt != d0) begin
            errors++;
            $display("FAIL len0_no_done: got %0d pulses, expected 0", done_cnt - d0);
        end
    endtask

    task automatic test_reset_midburst();
        int acc = 0, d0;
        bus.cfg_bias = 16'sd4; bus.cfg_scale = 16'sd2; bus.cfg_shift = 5'd1;
        bus.cfg_len = 16'd5; bus.cfg_bypass = 1'b0; bus.cfg_we = 1'b1;
        @(posedge clk); #1;
        bus.cfg_we    = 1'b0;
        bus.out_ready = 1'b0;
        for (int c = 0; c < 20 && acc < 2; c++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 16'($urandom);
            @(negedge clk); #1;
            if (bus.in_valid && bus.in_ready) acc++;
            @(posedge clk); #1;
        end
        checks++;
        if (acc != 2) begin
            errors++;
            $display("FAIL midrst_feed: accepted %0d, expected 2", acc);
        end
        d0 = done_cnt;
        bus.in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_idle_outputs("midrst_cleared");
        bus.out_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        checks++;
        if (done_cnt != d0 || bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL midrst_quiet: done pulses=%0d busy=%0b out_valid=%0b, expected 0 0 0",
                     done_cnt - d0, bus.busy, bus.out_valid);
        end
        stim.delete();
        for (int i = 0; i < 5; i++) stim.push_back(int'($urandom_range(65535)) - 32768);
        run_burst("post_reset", 4, 2, 1, 1'b0, 5, -1, -1, 1'b0, -1, 1'b0);
    endtask

    task automatic test_random();
        int len, bias, scale, shift;
        bit byp;
        for (int b = 0; b < 8; b++) begin
            len   = int'($urandom_range(1, 20));
            bias  = int'($urandom_range(65535)) - 32768;
            scale = int'($urandom_range(65535)) - 32768;
            shift = int'($urandom_range(0, 31));
            byp   = ($urandom_range(7) == 0);
            stim.delete();
            for (int i = 0; i < len; i++) stim.push_back(int'($urandom_range(65535)) - 32768);
            run_burst($sformatf("random%0d", b), bias, scale, shift, byp, len, -1, -1, 1'b1, -1, 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_rounding();
        test_saturation();
        test_backpressure();
        test_bypass_cfg();
        test_reset_midburst();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
